// File: rtl/dm_port_arbiter.sv
// Two-requester round-robin arbiter in front of the single-ported data memory.
// Decodes size/offset into byte lanes and returns a registered response one cycle after grant.
module dm_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int RR_INIT = 0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [31:0]       m0_pc,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [31:0]       m1_pc,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,

    output logic [3:0]        dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wd,
    input  logic [31:0]       dm_rd,
    output logic [31:0]       dm_pc
);

    typedef enum logic {
        PRI_M0 = 1'b0,
        PRI_M1 = 1'b1
    } pri_t;

    localparam pri_t PRI_RESET = (RR_INIT != 0) ? PRI_M1 : PRI_M0;

    pri_t              rr_pri;
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;

    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [31:0]       sel_pc;
    logic [1:0]        sel_off;

    logic              illegal;
    logic [3:0]        lanes;
    logic [31:0]       wd_rep;

    // Grants are suppressed while reset is high so no write reaches DM.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        if (!reset) begin
            gnt0 = m0_req && (!m1_req || (rr_pri == PRI_M0));
            gnt1 = m1_req && (!m0_req || (rr_pri == PRI_M1));
        end
        any_gnt = gnt0 || gnt1;
    end

    always_comb begin
        sel_we    = m0_we;
        sel_size  = m0_size;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        sel_pc    = m0_pc;
        if (gnt1) begin
            sel_we    = m1_we;
            sel_size  = m1_size;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_pc    = m1_pc;
        end
        sel_off = sel_addr[1:0];
    end

    always_comb begin
        illegal = 1'b0;
        lanes   = '0;
        wd_rep  = '0;
        case (sel_size)
            2'b00: begin
                lanes  = 4'b0001 << sel_off;
                wd_rep = {4{sel_wdata[7:0]}};
            end
            2'b01: begin
                illegal = sel_off[0];
                lanes   = 4'b0011 << sel_off;
                wd_rep  = {2{sel_wdata[15:0]}};
            end
            2'b10: begin
                illegal = (sel_off != 2'b00);
                lanes   = '1;
                wd_rep  = sel_wdata;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        dm_we   = '0;
        dm_addr = '0;
        dm_wd   = '0;
        dm_pc   = '0;
        if (any_gnt) begin
            dm_addr = sel_addr;
            dm_wd   = wd_rep;
            dm_pc   = sel_pc;
            if (sel_we && !illegal) begin
                dm_we = lanes;
            end
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_pri <= PRI_RESET;
        end else if (gnt0) begin
            rr_pri <= PRI_M1;
        end else if (gnt1) begin
            rr_pri <= PRI_M0;
        end
    end

    // rdata is the pre-write word for stores since DM updates on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
        end else begin
            m0_rvalid <= gnt0;
            m0_rdata  <= gnt0 ? dm_rd : '0;
            m0_err    <= gnt0 && illegal;
            m1_rvalid <= gnt1;
            m1_rdata  <= gnt1 ? dm_rd : '0;
            m1_err    <= gnt1 && illegal;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural byte-lane data memory behind the DM port.
module tb_dm_port_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata, m1_pc;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr, dm_wd, dm_rd, dm_pc;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:63];

    dm_port_arbiter #(.ADDR_W(32), .RR_INIT(0)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_pc(m0_pc), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_pc(m1_pc), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_rd(dm_rd), .dm_pc(dm_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
    end

    assign dm_rd = mem[dm_addr[7:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (dm_we[b]) mem[dm_addr[7:2]][8*b +: 8] <= dm_wd[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
        m0_req = req; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata; m0_pc = pc;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
        m1_req = req; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata; m1_pc = pc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        set_m0(0, 0, 2'b10, 0, 0, 0);
        set_m1(0, 0, 2'b10, 0, 0, 0);
        tick;
        tick;
        check("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
        check("rst_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_dm_we", {28'b0, dm_we}, 32'd0);
        check("rst_dm_addr", dm_addr, 32'd0);
        reset = 1'b0;

        // word store, m1 idle
        set_m0(1, 1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h100);
        settle;
        check("sw_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        check("sw_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        check("sw_dm_we", {28'b0, dm_we}, 32'hF);
        check("sw_dm_addr", dm_addr, 32'h10);
        check("sw_dm_wd", dm_wd, 32'hDEADBEEF);
        check("sw_dm_pc", dm_pc, 32'h100);
        tick;
        check("sw_rvalid", {31'b0, m0_rvalid}, 32'd1);
        check("sw_err", {31'b0, m0_err}, 32'd0);
        check("sw_rdata_prewrite", m0_rdata, 32'd0);

        set_m0(1, 0, 2'b10, 32'h10, 32'h0, 32'h104);
        settle;
        check("lw_dm_we", {28'b0, dm_we}, 32'h0);
        tick;
        check("lw_rdata", m0_rdata, 32'hDEADBEEF);

        set_m0(1, 1, 2'b00, 32'h13, 32'h000000AB, 32'h108);
        settle;
        check("sb_dm_we", {28'b0, dm_we}, 32'h8);
        check("sb_dm_wd", dm_wd, 32'hABABABAB);
        tick;
        set_m0(1, 1, 2'b01, 32'h22, 32'h00001234, 32'h10C);
        settle;
        check("sh_dm_we", {28'b0, dm_we}, 32'hC);
        check("sh_dm_wd", dm_wd, 32'h12341234);
        tick;
        set_m0(0, 0, 2'b10, 0, 0, 0);

        // round robin from reset, both requesting four cycles
        reset = 1'b1;
        tick;
        reset = 1'b0;
        set_m0(1, 0, 2'b10, 32'h10, 0, 32'h200);
        set_m1(1, 0, 2'b10, 32'h20, 0, 32'h300);
        for (int c = 0; c < 4; c++) begin
            settle;
            check("rr_m0_gnt", {31'b0, m0_gnt}, (c % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_m1_gnt", {31'b0, m1_gnt}, (c % 2 == 1) ? 32'd1 : 32'd0);
            check("rr_dm_addr", dm_addr, (c % 2 == 0) ? 32'h10 : 32'h20);
            tick;
            check("rr_m0_rvalid", {31'b0, m0_rvalid}, (c % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_m1_rvalid", {31'b0, m1_rvalid}, (c % 2 == 1) ? 32'd1 : 32'd0);
            if (c % 2 == 0) check("rr_m0_rdata", m0_rdata, 32'hABADBEEF);
            else            check("rr_m1_rdata", m1_rdata, 32'h12340000);
        end
        set_m0(0, 0, 2'b10, 0, 0, 0);
        set_m1(0, 0, 2'b10, 0, 0, 0);

        // misaligned word load and illegal size from m1
        set_m1(1, 0, 2'b10, 32'h06, 0, 32'h400);
        settle;
        check("mis_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        check("mis_dm_we", {28'b0, dm_we}, 32'h0);
        check("mis_dm_pc", dm_pc, 32'h400);
        tick;
        check("mis_rvalid", {31'b0, m1_rvalid}, 32'd1);
        check("mis_err", {31'b0, m1_err}, 32'd1);
        set_m1(1, 1, 2'b11, 32'h40, 32'hFFFFFFFF, 32'h404);
        settle;
        check("ill_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        check("ill_dm_we", {28'b0, dm_we}, 32'h0);
        tick;
        check("ill_err", {31'b0, m1_err}, 32'd1);
        set_m0(1, 0, 2'b10, 32'h10, 0, 32'h500);
        set_m1(1, 0, 2'b10, 32'h20, 0, 32'h408);
        settle;
        check("rot_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        check("rot_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        tick;
        check("rot_m0_err", {31'b0, m0_err}, 32'd0);
        set_m0(0, 0, 2'b10, 0, 0, 0);
        settle;
        check("rot_m1_late_gnt", {31'b0, m1_gnt}, 32'd1);
        tick;
        check("rot_m1_err", {31'b0, m1_err}, 32'd0);
        set_m1(0, 0, 2'b10, 0, 0, 0);

        // store then load back-to-back
        set_m0(1, 1, 2'b00, 32'h40, 32'h00000055, 32'h600);
        settle;
        check("st_dm_we", {28'b0, dm_we}, 32'h1);
        check("st_dm_wd", dm_wd, 32'h55555555);
        tick;
        check("st_rdata_prewrite", m0_rdata, 32'h0);
        set_m0(1, 0, 2'b10, 32'h40, 0, 32'h604);
        tick;
        check("ld_rvalid", {31'b0, m0_rvalid}, 32'd1);
        check("ld_rdata", m0_rdata, 32'h00000055);

        // reset during a store, with priority currently at m1
        reset = 1'b1;
        set_m0(1, 1, 2'b10, 32'h80, 32'hFFFFFFFF, 32'h700);
        settle;
        check("rs_m0_gnt", {31'b0, m0_gnt}, 32'd0);
        check("rs_dm_we", {28'b0, dm_we}, 32'h0);
        tick;
        reset = 1'b0;
        set_m0(0, 0, 2'b10, 0, 0, 0);
        settle;
        check("rs_rvalid_dropped", {31'b0, m0_rvalid}, 32'd0);
        set_m0(1, 0, 2'b10, 32'h80, 0, 32'h704);
        set_m1(1, 0, 2'b10, 32'h10, 0, 32'h800);
        settle;
        check("rs_pri_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        check("rs_pri_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        tick;
        check("rs_no_write", m0_rdata, 32'h0);
        set_m0(0, 0, 2'b10, 0, 0, 0);
        settle;
        check("rs_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        tick;
        check("rs_m1_rdata", m1_rdata, 32'hABADBEEF);
        set_m1(0, 0, 2'b10, 0, 0, 0);
        tick;
        check("idle_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
        check("idle_m1_rdata", m1_rdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-ported data memory (combinational read, byte-lane write on posedge clk) between two requesters.
- Requester 0 is the pipeline MEM stage; requester 1 is the secondary master (test loader / debug port).
- Arbitrates per cycle using round-robin priority and converts size/offset into byte-lane write enables and replicated write data.
- Rejects misaligned or illegal accesses, and returns read data and error status on a registered response one cycle after the grant.

Parameters:
- ADDR_W, 32, byte address width of both requesters and the DM port.
- RR_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  requester 0 access request
- m0_we  in  1  1 = store, 0 = load
- m0_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- m0_pc  in  32  PC of the issuing instruction, forwarded to the DM trace port
- m0_gnt  out  1  access accepted this cycle
- m0_rvalid  out  1  response valid, one cycle after m0_gnt
- m0_rdata  out  32  full DM word read at the granted address
- m0_err  out  1  qualifies m0_rvalid: access was misaligned or illegal
- m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_pc, m1_gnt, m1_rvalid, m1_rdata, m1_err: same definitions for requester 1
- dm_we  out  4  byte-lane write enables to DM
- dm_addr  out  ADDR_W  byte address to DM
- dm_wd  out  32  lane-replicated write data to DM
- dm_rd  in  32  combinational DM read word
- dm_pc  out  32  PC of the granted requester

Behaviour:
- Arbitration is combinational within the cycle and considers only asserted req lines.
  - One requester asserting is granted immediately.
  - Both asserting: the requester holding priority (register rr_pri) is granted.
  - After any grant, rr_pri moves to the other requester; with no grant it holds.
  - Reset sets rr_pri = RR_INIT.
- At most one gnt is high per cycle. A request not granted is stalled.
- A stalled requester keeps req and all fields stable until its gnt is seen. Fields may change freely in the cycle after gnt.
- Granted access drives dm_addr = granted address, dm_pc = granted pc.
- With no grant: dm_we = 0, dm_addr = 0, dm_wd = 0, dm_pc = 0.
- Lane rules, with o = addr[1:0]:
  - byte: dm_we = 4'b0001 << o; dm_wd = {4{wdata[7:0]}}.
  - half: dm_we = 4'b0011 << o; dm_wd = {2{wdata[15:0]}}.
  - word: dm_we = 4'b1111; dm_wd = wdata.
  - dm_we is nonzero only when granted, we = 1 and the access is legal.
- Illegal access: half with o[0] = 1, word with o != 0, or size = 11.
  - Still granted, so it consumes its slot and rotates priority.
  - dm_we forced to 0.
  - Next cycle: rvalid = 1 and err = 1.
- Response register:
  - On the cycle after gnt, mX_rvalid = 1 for exactly one cycle.
  - mX_rdata = dm_rd sampled at the grant edge. For stores this is the pre-write word.
  - mX_err as above.
  - Response outputs of a non-granted requester are 0.
- Back-to-back: a requester may be granted every cycle if the other is idle. Each grant gets its own one-cycle-later response; there is no response queue.
- Reset (sync) clears rr_pri to RR_INIT and all rvalid, rdata and err to 0.
  - A grant in the reset cycle is suppressed: gnt = 0, dm_we = 0.
  - A response due in the cycle after reset is dropped.
- Reset values of all outputs are 0; combinational outputs are 0 while reset = 1.
- Address bits above the DM size are passed through unmodified; range checking is owned by DM.

Test Plan:
- m0 sw addr 0x10, wdata 0xDEADBEEF, m1 idle -> same cycle m0_gnt = 1, dm_we = 1111, dm_addr = 0x10; next cycle m0_rvalid = 1, m0_err = 0; later a word read at 0x10 returns 0xDEADBEEF.
- m0 sb addr 0x13, wdata 0x000000AB -> dm_we = 1000, dm_wd = 0xABABABAB; m0 sh addr 0x22, wdata 0x1234 -> dm_we = 1100, dm_wd = 0x12341234.
- Both requesters assert for 4 cycles after reset with RR_INIT = 0 -> grants alternate m0, m1, m0, m1; loser stalls with fields stable; each rvalid follows its gnt by one cycle.
- m1 lw addr 0x06 -> m1_gnt = 1, dm_we = 0000, next cycle m1_rvalid = 1, m1_err = 1; size = 11 also gives err = 1; priority rotates to m0.
- Store 0x55 at 0x40, then load 0x40 in the next cycle -> m0_rdata = 0x00000055 one cycle after the load's gnt; the store's own response carries the pre-write word 0x00000000.
- Assert reset during a granted m0 store to 0x80 -> no write (0x80 reads 0), m0_rvalid stays 0 the next cycle, rr_pri = RR_INIT.
